// File: rtl/adc_pkt_framer.sv
// ADC capture output framer: reads stored samples over valid/ready and emits
// headered packets separated by gap_len idle cycles, ending each run with idle_len idle cycles.
module adc_pkt_framer #(
    parameter int DATA_W = 18,
    parameter int GAP_W  = 8,
    parameter int IDLE_W = 8,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              again,
    input  logic [1:0]        len_sel,
    input  logic [GAP_W-1:0]  gap_len,
    input  logic [IDLE_W-1:0] idle_len,
    input  logic [7:0]        pkt_num,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int WAIT_W = (GAP_W > IDLE_W) ? GAP_W : IDLE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_GAP,
        S_TAIL,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_len_sel;
    logic [GAP_W-1:0]    r_gap_len;
    logic [IDLE_W-1:0]   r_idle_len;
    logic [7:0]          r_pkt_last;
    logic [CNT_W-1:0]    r_sample_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [7:0]          r_pkt_cnt;
    logic [7:0]          r_seq;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_done;

    logic [CNT_W-1:0]    w_last_idx;
    logic [WAIT_W-1:0]   w_wait_lim;
    logic                w_wait_end;
    logic                w_hs;

    always_comb begin
        w_last_idx = CNT_W'(215);
        case (r_len_sel)
            2'b00:   w_last_idx = CNT_W'(215);
            2'b01:   w_last_idx = CNT_W'(431);
            2'b10:   w_last_idx = CNT_W'(863);
            default: w_last_idx = CNT_W'(1727);
        endcase
    end

    // One shared wait counter serves both GAP and TAIL; they are never active together
    assign w_wait_lim = (r_state == S_GAP) ? WAIT_W'(r_gap_len) : WAIT_W'(r_idle_len);
    assign w_wait_end = (r_wait_cnt == w_wait_lim - WAIT_W'(1));
    assign w_hs       = in_valid & in_ready;

    assign in_ready  = (r_state == S_DATA);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len_sel    <= '0;
            r_gap_len    <= '0;
            r_idle_len   <= '0;
            r_pkt_last   <= '0;
            r_sample_cnt <= '0;
            r_wait_cnt   <= '0;
            r_pkt_cnt    <= '0;
            r_seq        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (start || again) begin
                        r_len_sel    <= len_sel;
                        r_gap_len    <= gap_len;
                        r_idle_len   <= idle_len;
                        r_pkt_last   <= (pkt_num == 8'd0) ? 8'd0 : pkt_num - 8'd1;
                        r_pkt_cnt    <= '0;
                        r_sample_cnt <= '0;
                        r_wait_cnt   <= '0;
                        if (start)
                            r_seq <= '0;
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= DATA_W'({2'b11, r_seq, r_len_sel, 6'b0});
                    r_state     <= S_DATA;
                end
                S_DATA: begin
                    r_out_valid <= w_hs;
                    if (w_hs) begin
                        r_out_data <= in_data;
                        if (r_sample_cnt == w_last_idx) begin
                            r_sample_cnt <= '0;
                            r_wait_cnt   <= '0;
                            r_seq        <= r_seq + 8'd1;
                            r_pkt_cnt    <= r_pkt_cnt + 8'd1;
                            if (r_pkt_cnt == r_pkt_last) begin
                                if (r_idle_len == '0) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_TAIL;
                                end
                            end else begin
                                r_state <= (r_gap_len == '0) ? S_HDR : S_GAP;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    r_out_valid <= 1'b0;
                    if (w_wait_end) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_HDR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_TAIL: begin
                    r_out_valid <= 1'b0;
                    if (w_wait_end) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_pkt_framer.sv
// Directed bench for adc_pkt_framer: a table of run configurations with hand-computed
// packet shapes, plus hand-written reset and abort sequences.
module tb_adc_pkt_framer;

    localparam int DATA_W = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              again;
    logic [1:0]        len_sel;
    logic [7:0]        gap_len;
    logic [7:0]        idle_len;
    logic [7:0]        pkt_num;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;

    adc_pkt_framer #(.DATA_W(18), .GAP_W(8), .IDLE_W(8), .CNT_W(11)) dut (
        .clk(clk), .rst(rst), .start(start), .again(again),
        .len_sel(len_sel), .gap_len(gap_len), .idle_len(idle_len), .pkt_num(pkt_num),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // op: 1=start, 2=again, 3=start+again; poke_at: cycle to pulse start and scramble config
    typedef struct {
        int         op;
        logic [1:0] len_sel;
        int         pkt_num;
        int         gap;
        int         idle;
        int         stall_at;
        int         stall_len;
        int         poke_at;
        int         exp_seq0;
        int         exp_n;
        int         exp_pkts;
    } vec_t;

    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   src_val = 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, words = 0, pkt = 0, wip = 0, run = 0;
        int data_bad = 0, gap_bad = 0, stall_runs = 0, stall_sum = 0, busy_bad = 0;
        int hdr_cyc = -1, last_cyc = -1, done_cyc = -1;
        int sent = 0, stall_left = 0, limit, total, seq, exp_val;
        bit stalled = 0;
        logic [DATA_W-1:0] exp_w;
        string tag;
        tag     = $sformatf("v%0d", idx);
        total   = v.exp_pkts * (v.exp_n + 1);
        limit   = v.exp_pkts * (v.exp_n + 1 + v.gap) + v.idle + v.stall_len + 50;
        seq     = v.exp_seq0;
        exp_val = src_val;

        @(negedge clk);
        len_sel  = v.len_sel;
        gap_len  = 8'(v.gap);
        idle_len = 8'(v.idle);
        pkt_num  = 8'(v.pkt_num);
        start    = (v.op != 2);
        again    = (v.op != 1);
        in_valid = 1'b1;
        in_data  = DATA_W'(src_val);

        while (done_cyc < 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            again = 1'b0;
            if (cyc == v.poke_at) begin
                start    = 1'b1;
                len_sel  = ~v.len_sel;
                gap_len  = 8'(v.gap + 3);
                idle_len = 8'(v.idle + 7);
                pkt_num  = 8'd9;
            end
            if (!busy) busy_bad++;
            if (out_valid) begin
                if (words >= total) begin
                    data_bad++;
                end else begin
                    if (wip == 0) begin
                        exp_w = DATA_W'({2'b11, 8'(seq), v.len_sel, 6'b0});
                        if (pkt == 0) hdr_cyc = cyc;
                        else if (run != v.gap) gap_bad++;
                    end else begin
                        exp_w = DATA_W'(exp_val);
                        exp_val++;
                        if (run > 0) begin
                            stall_runs++;
                            stall_sum += run;
                        end
                    end
                    if (out_data !== exp_w) data_bad++;
                    wip++;
                    if (wip == v.exp_n + 1) begin
                        wip = 0;
                        pkt++;
                        seq = (seq + 1) % 256;
                        last_cyc = cyc;
                    end
                end
                words++;
                run = 0;
            end else begin
                run++;
            end
            if (done) done_cyc = cyc;

            if (stall_left > 0) begin
                in_valid = 1'b0;
                stall_left--;
            end else if (v.stall_len > 0 && !stalled && sent == v.stall_at) begin
                stalled    = 1;
                in_valid   = 1'b0;
                stall_left = v.stall_len - 1;
            end else begin
                in_valid = 1'b1;
            end
            in_data = DATA_W'(src_val);
            if (in_valid && in_ready) begin
                sent++;
                src_val++;
            end
        end

        check({tag, " done_seen"},  int'(done_cyc >= 0), 1);
        check({tag, " hdr_cycle"},  hdr_cyc, 2);
        check({tag, " words"},      words, total);
        check({tag, " data_bad"},   data_bad, 0);
        check({tag, " gap_bad"},    gap_bad, 0);
        check({tag, " stall_sum"},  stall_sum, v.stall_len);
        check({tag, " stall_runs"}, stall_runs, (v.stall_len > 0) ? 1 : 0);
        check({tag, " tail_len"},   done_cyc - last_cyc, v.idle);
        check({tag, " busy_low"},   busy_bad, 0);

        @(negedge clk);
        check({tag, " done_pulse"}, int'(done), 0);
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " rdy_after"},  int'(in_ready), 0);
    endtask

    initial begin
        vec_t fresh;
        int   hi;
        rst = 1'b1; start = 1'b0; again = 1'b0; len_sel = '0; gap_len = '0;
        idle_len = '0; pkt_num = '0; in_data = '0; in_valid = 1'b0;

        //          op len   pk gap idl  st_at st_len poke seq0  n    pkts
        vecs[0] = '{1, 2'b00, 1, 8, 15,  0,    0,    0,   0,  216,  1};
        vecs[1] = '{1, 2'b10, 3, 8,  4,  0,    0,    0,   0,  864,  3};
        vecs[2] = '{1, 2'b00, 2, 0,  3,  0,    0,    0,   0,  216,  2};
        vecs[3] = '{1, 2'b00, 1, 5,  2, 100,   5,    0,   0,  216,  1};
        vecs[4] = '{1, 2'b00, 3, 2,  1,  0,    0,   50,   0,  216,  3};
        vecs[5] = '{2, 2'b01, 1, 3,  0,  0,    0,    0,   3,  432,  1};
        vecs[6] = '{3, 2'b11, 0, 1,  2,  0,    0,    0,   0, 1728,  1};
        vecs[7] = '{2, 2'b00, 1, 0,  0,  0,    0,    0,   1,  216,  1};

        repeat (3) @(negedge clk);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data",  int'(out_data), 0);
        check("rst busy",      int'(busy), 0);
        check("rst done",      int'(done), 0);
        check("rst in_ready",  int'(in_ready), 0);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(src_val);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Abort mid-DATA: outputs clear at once, no done, nothing emitted afterwards
        @(negedge clk);
        len_sel = 2'b00; gap_len = '0; idle_len = '0; pkt_num = 8'd1; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start   = 1'b0;
            in_data = DATA_W'(src_val);
            if (in_valid && in_ready) src_val++;
        end
        check("abort pre valid", int'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort out_valid", int'(out_valid), 0);
        check("abort out_data",  int'(out_data), 0);
        check("abort busy",      int'(busy), 0);
        check("abort in_ready",  int'(in_ready), 0);
        check("abort done",      int'(done), 0);
        rst = 1'b0;
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid || done || busy) hi++;
        end
        check("abort quiet", hi, 0);

        fresh = '{1, 2'b00, 2, 4, 6, 0, 0, 0, 0, 216, 2};
        run_vec(8, fresh);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
